// File: rtl/ahb_slave_mux_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_mux_pkg
// Description : Shared types and constants for the AHB-Lite slave response
//               multiplexer: HTRANS/HRESP encodings, the FSM state type and
//               a select-vector classification helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_mux_pkg;

    // AHB-Lite transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB-Lite responses
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Largest supported port count; select vectors are classified at this width
    localparam int MAX_PORTS = 32;

    // Response-path states: pass-through, default-slave error, watchdog error
    typedef enum logic [2:0] {
        PASS  = 3'd0,
        DERR1 = 3'd1,
        DERR2 = 3'd2,
        TERR1 = 3'd3,
        TERR2 = 3'd4
    } mux_state_t;

    // Classification of a select vector
    typedef enum logic [1:0] {
        SEL_ZERO  = 2'd0,
        SEL_ONE   = 2'd1,
        SEL_MULTI = 2'd2
    } sel_kind_t;

    // Zero / one-hot / multi-hot check; clearing the lowest set bit leaves
    // zero exactly when a single bit was set.
    function automatic sel_kind_t sel_kind(input logic [MAX_PORTS-1:0] vec);
        sel_kind_t kind;
        if (vec == '0) begin
            kind = SEL_ZERO;
        end else if ((vec & (vec - 1'b1)) == '0) begin
            kind = SEL_ONE;
        end else begin
            kind = SEL_MULTI;
        end
        return kind;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_slave_mux_param_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_mux_param_if
// Description : Bus bundle between the master, the address decoder, the slave
//               ports and the response multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_slave_mux_param_if #(
    parameter int NPORT = 9,
    parameter int DW    = 32
);
    logic                  HREADY;
    logic [1:0]            HTRANS;
    logic [NPORT-1:0]      HSEL_VEC;
    logic [NPORT-1:0]      HREADYOUT_VEC;
    logic [NPORT-1:0]      HRESP_VEC;
    logic [NPORT*DW-1:0]   HRDATA_BUS;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [DW-1:0]         HRDATA;
    logic                  TOUT_IRQ;
    logic                  SEL_ERR;

    // Multiplexer side
    modport slave (
        input  HREADY, HTRANS, HSEL_VEC, HREADYOUT_VEC, HRESP_VEC, HRDATA_BUS,
        output HREADYOUT, HRESP, HRDATA, TOUT_IRQ, SEL_ERR
    );

    // Master / interconnect / slave-port side
    modport master (
        output HREADY, HTRANS, HSEL_VEC, HREADYOUT_VEC, HRESP_VEC, HRDATA_BUS,
        input  HREADYOUT, HRESP, HRDATA, TOUT_IRQ, SEL_ERR
    );
endinterface
`default_nettype wire

// File: rtl/ahb_slave_mux_param_wdog.sv
`default_nettype none
// ============================================================================
// Module      : ahb_mux_wdog
// Description : Consecutive wait-state counter. Fires for one cycle when the
//               enable has been high for TOUT_CYC cycles in a row; a
//               TOUT_CYC of zero disables it.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_mux_wdog #(
    parameter int TOUT_W   = 8,
    parameter int TOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic fire
);
    localparam bit              WD_ON = (TOUT_CYC != 0);
    localparam logic [TOUT_W-1:0] LIMIT = WD_ON ? TOUT_W'(TOUT_CYC - 1) : '0;

    logic [TOUT_W-1:0] count_q;

    // Fire on the stalled cycle that completes the allowed wait budget
    assign fire = WD_ON && en && (count_q == LIMIT);

    // Count stalled cycles; any break in the stall or a fire starts over
    always_ff @(posedge clk) begin
        if (rst || !en || fire || !WD_ON) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/ahb_slave_mux_param.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_mux_param
// Description : AHB-Lite slave response multiplexer with a built-in default
//               slave (unmapped / multi-hot selects) and a per-transfer hang
//               watchdog that forces a two-cycle ERROR on stalled slaves.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_mux_param
    import ahb_mux_pkg::*;
#(
    parameter int NPORT    = 9,
    parameter int DW       = 32,
    parameter int TOUT_W   = 8,
    parameter int TOUT_CYC = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_slave_mux_param_if.slave  bus
);
    logic [NPORT-1:0] sel_q;
    logic             act_q;
    mux_state_t       state_q;
    mux_state_t       state_d;

    sel_kind_t        sel_q_kind;
    logic             addr_unmapped;
    logic             slv_ready;
    logic             slv_resp;
    logic [DW-1:0]    slv_data;
    logic             wd_en;
    logic             wd_fire;

    logic             out_ready;
    logic             out_resp;
    logic [DW-1:0]    out_data;
    logic             out_irq;
    logic             out_sel_err;

    // HTRANS[0] only separates IDLE/BUSY and NONSEQ/SEQ; routing ignores it
    logic             unused_htrans0;
    assign unused_htrans0 = bus.HTRANS[0];

    assign sel_q_kind = sel_kind(MAX_PORTS'(sel_q));

    // An active transfer addressed to nobody or to several slaves goes to the
    // default slave
    assign addr_unmapped = bus.HREADY && bus.HTRANS[1] &&
                           (sel_kind(MAX_PORTS'(bus.HSEL_VEC)) != SEL_ONE);

    // Capture the address-phase select and activity on every accepted phase
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q <= '0;
            act_q <= 1'b0;
        end else if (bus.HREADY) begin
            sel_q <= bus.HSEL_VEC;
            act_q <= bus.HTRANS[1];
        end
    end

    // AND-OR select of the data-phase slave; only meaningful when one-hot
    always_comb begin
        slv_ready = 1'b0;
        slv_resp  = 1'b0;
        slv_data  = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (sel_q[i]) begin
                slv_ready = slv_ready | bus.HREADYOUT_VEC[i];
                slv_resp  = slv_resp  | bus.HRESP_VEC[i];
                slv_data  = slv_data  | bus.HRDATA_BUS[i*DW +: DW];
            end
        end
    end

    // Watchdog runs only while a real transfer to a single slave is stalled
    assign wd_en = (state_q == PASS) && act_q && (sel_q_kind == SEL_ONE) && !slv_ready;

    ahb_mux_wdog #(
        .TOUT_W   (TOUT_W),
        .TOUT_CYC (TOUT_CYC)
    ) u_wdog (
        .clk  (HCLK),
        .rst  (HRESET),
        .en   (wd_en),
        .fire (wd_fire)
    );

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= PASS;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: error sequences are two cycles; their second cycle overlaps
    // the next address phase, so a new unmapped access chains straight in
    always_comb begin
        state_d = state_q;
        case (state_q)
            PASS: begin
                if (wd_fire) begin
                    state_d = TERR1;
                end else if (addr_unmapped) begin
                    state_d = DERR1;
                end else begin
                    state_d = PASS;
                end
            end
            DERR1:   state_d = DERR2;
            TERR1:   state_d = TERR2;
            DERR2,
            TERR2:   state_d = addr_unmapped ? DERR1 : PASS;
            default: state_d = PASS;
        endcase
    end

    // Output decode: pass the selected slave through, or drive the error phases
    always_comb begin
        out_ready   = 1'b1;
        out_resp    = HRESP_OKAY;
        out_data    = '0;
        out_irq     = 1'b0;
        out_sel_err = 1'b0;
        case (state_q)
            PASS: begin
                if (sel_q_kind == SEL_ONE) begin
                    out_ready = slv_ready;
                    out_resp  = slv_resp;
                    out_data  = slv_data;
                end
            end
            DERR1: begin
                out_ready   = 1'b0;
                out_resp    = HRESP_ERROR;
                out_sel_err = 1'b1;
            end
            DERR2: begin
                out_resp = HRESP_ERROR;
            end
            TERR1: begin
                out_ready = 1'b0;
                out_resp  = HRESP_ERROR;
                out_irq   = 1'b1;
            end
            TERR2: begin
                out_resp = HRESP_ERROR;
            end
            default: begin
                out_ready = 1'b1;
            end
        endcase
    end

    assign bus.HREADYOUT = out_ready;
    assign bus.HRESP     = out_resp;
    assign bus.HRDATA    = out_data;
    assign bus.TOUT_IRQ  = out_irq;
    assign bus.SEL_ERR   = out_sel_err;
endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_mux_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_slave_mux_param
// Description : Self-checking bench for ahb_slave_mux_param. A transfer-level
//               reference model predicts every output each cycle; directed
//               scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_mux_param;
    import ahb_mux_pkg::*;

    localparam int NP = 9;
    localparam int DW = 32;
    localparam int TW = 8;
    localparam int TC = 4;
    localparam logic [NP-1:0] ALL1 = '1;
    localparam logic [NP-1:0] NONE = '0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ahb_slave_mux_param_if #(.NPORT(NP), .DW(DW)) bus ();

    // Single-master system: the mux's ready is the bus-wide HREADY
    assign bus.HREADY = bus.HREADYOUT;

    ahb_slave_mux_param #(
        .NPORT    (NP),
        .DW       (DW),
        .TOUT_W   (TW),
        .TOUT_CYC (TC)
    ) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: the transfer in its data phase and any forced error
    logic [NP-1:0] m_sel;
    logic          m_act;
    int            m_err_left;   // forced-error cycles still to come (2, 1, 0)
    logic          m_tout;       // forced error came from the watchdog
    int            m_waits;      // consecutive stalled cycles so far

    logic          e_rdy, e_resp, e_irq, e_serr;
    logic [DW-1:0] e_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NP-1:0] oh(input int p);
        logic [NP-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic logic [NP*DW-1:0] rnd_data();
        logic [NP*DW-1:0] d;
        for (int i = 0; i < NP; i++) d[i*DW +: DW] = $urandom;
        return d;
    endfunction

    // Port number of a single-slave select, -1 otherwise
    function automatic int port_of(input logic [NP-1:0] s);
        int k;
        k = -1;
        if ($countones(s) == 1)
            for (int i = 0; i < NP; i++) if (s[i]) k = i;
        return k;
    endfunction

    task automatic model_reset();
        m_sel = '0; m_act = 1'b0; m_err_left = 0; m_tout = 1'b0; m_waits = 0;
    endtask

    task automatic model_expect(input logic [NP-1:0] rdy, input logic [NP-1:0] rsp,
                                input logic [NP*DW-1:0] data);
        int k;
        k = port_of(m_sel);
        e_rdy = 1'b1; e_resp = 1'b0; e_data = '0; e_irq = 1'b0; e_serr = 1'b0;
        if (m_err_left == 2) begin
            e_rdy = 1'b0; e_resp = 1'b1; e_irq = m_tout; e_serr = !m_tout;
        end else if (m_err_left == 1) begin
            e_resp = 1'b1;
        end else if (k >= 0) begin
            e_rdy = rdy[k]; e_resp = rsp[k]; e_data = data[k*DW +: DW];
        end
    endtask

    task automatic model_step(input logic r, input logic [1:0] tr,
                              input logic [NP-1:0] sel, input logic [NP-1:0] rdy);
        int   k;
        logic stall;
        k = port_of(m_sel);
        stall = 1'b0;
        if (m_err_left == 0 && m_act && k >= 0) stall = !rdy[k];
        if (r) begin
            model_reset();
        end else begin
            if (m_err_left == 2) begin
                m_err_left = 1;
            end else if (stall && (m_waits + 1 == TC)) begin
                m_err_left = 2; m_tout = 1'b1;
            end else if (e_rdy && tr[1] && $countones(sel) != 1) begin
                m_err_left = 2; m_tout = 1'b0;
            end else begin
                m_err_left = 0;
            end
            m_waits = (stall && m_err_left != 2) ? m_waits + 1 : 0;
            if (e_rdy) begin
                m_sel = sel; m_act = tr[1];
            end
        end
    endtask

    // One bus cycle: drive after the falling edge, check, then advance the model
    task automatic cyc(input logic r, input logic [1:0] tr, input logic [NP-1:0] sel,
                       input logic [NP-1:0] rdy, input logic [NP-1:0] rsp,
                       input logic [NP*DW-1:0] data);
        @(negedge clk);
        rst = r;
        bus.HTRANS = tr;
        bus.HSEL_VEC = sel;
        bus.HREADYOUT_VEC = rdy;
        bus.HRESP_VEC = rsp;
        bus.HRDATA_BUS = data;
        #1;
        model_expect(rdy, rsp, data);
        chk("hreadyout", bus.HREADYOUT, e_rdy);
        chk("hresp",     bus.HRESP,     e_resp);
        chk("hrdata",    bus.HRDATA,    e_data);
        chk("tout_irq",  bus.TOUT_IRQ,  e_irq);
        chk("sel_err",   bus.SEL_ERR,   e_serr);
        model_step(r, tr, sel, rdy);
    endtask

    initial begin
        logic [NP*DW-1:0] d;
        logic [NP-1:0]    rdy, rsp, sel;
        int               pstall, a, b;

        bus.HTRANS = HTRANS_IDLE; bus.HSEL_VEC = '0; bus.HREADYOUT_VEC = ALL1;
        bus.HRESP_VEC = '0; bus.HRDATA_BUS = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state and idle bus
        cyc(1'b1, HTRANS_IDLE, NONE, ALL1, NONE, rnd_data());
        chk("rst_ready", bus.HREADYOUT, 1'b1);
        chk("rst_data",  bus.HRDATA, 32'h0);
        repeat (3) cyc(1'b0, HTRANS_IDLE, NONE, ALL1, NONE, rnd_data());
        chk("idle_resp", bus.HRESP, 1'b0);

        // Port 3 read with one wait state
        cyc(1'b0, HTRANS_NONSEQ, oh(3), ALL1, NONE, rnd_data());
        cyc(1'b0, HTRANS_IDLE, NONE, ALL1 & ~oh(3), NONE, rnd_data());
        chk("p3_wait", bus.HREADYOUT, 1'b0);
        d = rnd_data(); d[3*DW +: DW] = 32'hDEADBEEF;
        cyc(1'b0, HTRANS_IDLE, NONE, ALL1, NONE, d);
        chk("p3_ready", bus.HREADYOUT, 1'b1);
        chk("p3_data",  bus.HRDATA, 32'hDEADBEEF);

        // Unmapped access followed directly by a multi-hot access
        cyc(1'b0, HTRANS_NONSEQ, NONE, ALL1, NONE, rnd_data());
        cyc(1'b0, HTRANS_NONSEQ, 9'h005, ALL1, NONE, rnd_data());
        chk("derr1_a_ready", bus.HREADYOUT, 1'b0);
        chk("derr1_a_selerr", bus.SEL_ERR, 1'b1);
        cyc(1'b0, HTRANS_NONSEQ, 9'h005, ALL1, NONE, rnd_data());
        chk("derr2_a_resp", {bus.HREADYOUT, bus.HRESP}, 2'b11);
        cyc(1'b0, HTRANS_IDLE, NONE, ALL1, NONE, rnd_data());
        chk("derr1_b_resp", {bus.HREADYOUT, bus.HRESP}, 2'b01);
        chk("derr1_b_selerr", bus.SEL_ERR, 1'b1);
        cyc(1'b0, HTRANS_IDLE, NONE, ALL1, NONE, rnd_data());
        chk("derr2_b_resp", {bus.HREADYOUT, bus.HRESP}, 2'b11);
        cyc(1'b0, HTRANS_IDLE, NONE, ALL1, NONE, rnd_data());

        // Port 0 hangs: four waits, then the watchdog error, then port 1 OKAY
        cyc(1'b0, HTRANS_NONSEQ, oh(0), ALL1, NONE, rnd_data());
        rdy = ALL1 & ~oh(0);
        for (int w = 0; w < TC; w++) begin
            cyc(1'b0, HTRANS_NONSEQ, oh(1), rdy, NONE, rnd_data());
            chk("tout_wait", {bus.HREADYOUT, bus.TOUT_IRQ}, 2'b00);
        end
        cyc(1'b0, HTRANS_NONSEQ, oh(1), rdy, NONE, rnd_data());
        chk("terr1", {bus.HREADYOUT, bus.HRESP, bus.TOUT_IRQ}, 3'b011);
        cyc(1'b0, HTRANS_NONSEQ, oh(1), rdy, NONE, rnd_data());
        chk("terr2", {bus.HREADYOUT, bus.HRESP, bus.TOUT_IRQ}, 3'b110);
        d = rnd_data();
        cyc(1'b0, HTRANS_IDLE, NONE, rdy, NONE, d);
        chk("p1_okay", {bus.HREADYOUT, bus.HRESP}, 2'b10);
        chk("p1_data", bus.HRDATA, d[1*DW +: DW]);

        // Port 5 issues its own two-cycle ERROR
        cyc(1'b0, HTRANS_NONSEQ, oh(5), ALL1, NONE, rnd_data());
        cyc(1'b0, HTRANS_IDLE, NONE, ALL1 & ~oh(5), oh(5), rnd_data());
        chk("p5_err1", {bus.HREADYOUT, bus.HRESP, bus.TOUT_IRQ}, 3'b010);
        cyc(1'b0, HTRANS_IDLE, NONE, ALL1, oh(5), rnd_data());
        chk("p5_err2", {bus.HREADYOUT, bus.HRESP, bus.TOUT_IRQ}, 3'b110);
        cyc(1'b0, HTRANS_IDLE, NONE, ALL1, NONE, rnd_data());

        // Reset during DERR1
        cyc(1'b0, HTRANS_NONSEQ, NONE, ALL1, NONE, rnd_data());
        cyc(1'b1, HTRANS_IDLE, NONE, ALL1, NONE, rnd_data());
        cyc(1'b0, HTRANS_IDLE, NONE, ALL1, NONE, rnd_data());
        chk("rst_derr", {bus.HREADYOUT, bus.HRESP, bus.SEL_ERR}, 3'b100);

        // Reset during a 3-cycle stall; the next stall gets the full budget
        cyc(1'b0, HTRANS_NONSEQ, oh(2), ALL1, NONE, rnd_data());
        rdy = ALL1 & ~oh(2);
        cyc(1'b0, HTRANS_IDLE, NONE, rdy, NONE, rnd_data());
        cyc(1'b0, HTRANS_IDLE, NONE, rdy, NONE, rnd_data());
        cyc(1'b1, HTRANS_IDLE, NONE, rdy, NONE, rnd_data());
        cyc(1'b0, HTRANS_NONSEQ, oh(2), rdy, NONE, rnd_data());
        chk("rst_stall", {bus.HREADYOUT, bus.HRESP, bus.HRDATA}, {2'b10, 32'h0});
        for (int w = 0; w < TC; w++) begin
            cyc(1'b0, HTRANS_IDLE, NONE, rdy, NONE, rnd_data());
            chk("restall_wait", bus.TOUT_IRQ, 1'b0);
        end
        cyc(1'b0, HTRANS_IDLE, NONE, rdy, NONE, rnd_data());
        chk("restall_terr1", bus.TOUT_IRQ, 1'b1);
        cyc(1'b0, HTRANS_IDLE, NONE, ALL1, NONE, rnd_data());

        // Randomized traffic in segments of differing stall likelihood
        for (int seg = 0; seg < 30; seg++) begin
            case ($urandom_range(0, 2))
                0:       pstall = 10;
                1:       pstall = 50;
                default: pstall = 95;
            endcase
            for (int c = 0; c < 40; c++) begin
                a = $urandom_range(0, 99);
                if (a < 60) begin
                    sel = oh($urandom_range(0, NP-1));
                end else if (a < 75) begin
                    sel = '0;
                end else if (a < 90) begin
                    a = $urandom_range(0, NP-1);
                    b = (a + 1 + $urandom_range(0, NP-2)) % NP;
                    sel = oh(a) | oh(b);
                end else begin
                    sel = NP'($urandom);
                end
                for (int i = 0; i < NP; i++) begin
                    rdy[i] = ($urandom_range(0, 99) >= pstall);
                    rsp[i] = ($urandom_range(0, 9) == 0);
                end
                cyc(($urandom_range(0, 199) == 0), 2'($urandom_range(0, 3)),
                    sel, rdy, rsp, rnd_data());
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
